// File: rtl/vector_divide_unit_pkg.sv
// vector_divide_unit_pkg
// Shared vector types for the lane divider: div_type encodings, the divider
// state enum and a small absolute-value helper used when loading operands.
package vector_divide_unit_pkg;

  localparam int DIV_WIDTH = 32;

  // div_type encoding
  localparam logic DIV_QUOT = 1'b0;
  localparam logic DIV_REM  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_FIXUP  = 2'd2,
    ST_DONE   = 2'd3
  } div_state_e;

  // Magnitude of a possibly signed operand; unsigned operands pass through.
  function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] v,
                                                   input logic is_signed);
    return (is_signed && v[DIV_WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/vector_divide_unit_step.sv
// vector_div_step
// One combinational restoring shift-subtract iteration.
// Ports:
//   rem      - current 33-bit partial remainder
//   quo      - quotient shift register (dividend bits shift out of the top)
//   dvsr     - divisor magnitude
//   rem_next - partial remainder after this iteration
//   quo_next - quotient register after this iteration (new bit in LSB)
module vector_div_step (
  input  logic [32:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] dvsr,
  output logic [32:0] rem_next,
  output logic [31:0] quo_next
);

  logic [33:0] shifted;
  logic [33:0] diff;

  // One guard bit above the 33-bit remainder: a set top bit of diff means
  // the trial subtraction went negative and the remainder is restored.
  assign shifted = {rem, quo[31]};
  assign diff    = shifted - {2'b00, dvsr};

  always_comb begin
    rem_next = shifted[32:0];
    quo_next = {quo[30:0], 1'b0};
    if (!diff[33]) begin
      rem_next = diff[32:0];
      quo_next = {quo[30:0], 1'b1};
    end
  end

endmodule

// File: rtl/vector_divide_unit.sv
// vector_divide_unit
// Iterative 32-bit divider for one vector lane (vdiv/vdivu/vrem/vremu).
// Divide-by-zero and signed overflow finish in one cycle; everything else
// runs 32 restoring steps plus one sign-fixup cycle (34-cycle latency).
// Ports:
//   CLK, nRST     - clock, asynchronous active-low reset
//   vs1_data      - divisor
//   vs2_data      - dividend
//   start_div     - start request, accepted in IDLE or DONE only
//   div_type      - 0 quotient, 1 remainder
//   is_signed_div - 1 two's-complement operands
//   wdata_du      - registered result, held until the next result
//   busy_du       - high in DIVIDE and FIXUP
//   done_du       - one-cycle result-valid pulse
//   exception_du  - always 0
//
// state  | meaning
// IDLE   | waiting for start_div
// DIVIDE | one restoring step per cycle, counter 0..31
// FIXUP  | apply result signs, write wdata_du
// DONE   | done_du high; a new start is accepted here as in IDLE
module vector_divide_unit
  import vector_divide_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] vs1_data,
  input  logic [WIDTH-1:0] vs2_data,
  input  logic             start_div,
  input  logic             div_type,
  input  logic             is_signed_div,
  output logic [WIDTH-1:0] wdata_du,
  output logic             busy_du,
  output logic             done_du,
  output logic             exception_du
);

  div_state_e       state;
  logic [4:0]       cnt;
  logic [32:0]      rem;
  logic [31:0]      quo;
  logic [31:0]      dvsr;
  logic             neg_q;
  logic             neg_r;
  logic             dtype;

  logic [32:0]      rem_next;
  logic [31:0]      quo_next;

  logic             accept;
  logic             div_zero;
  logic             sgn_ovf;
  logic [31:0]      special_res;
  logic [31:0]      q_fix;
  logic [31:0]      r_fix;

  vector_div_step u_step (
    .rem      (rem),
    .quo      (quo),
    .dvsr     (dvsr),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  assign accept   = start_div && ((state == ST_IDLE) || (state == ST_DONE));
  assign div_zero = (vs1_data == '0);
  assign sgn_ovf  = is_signed_div && (vs2_data == 32'h8000_0000) &&
                    (vs1_data == 32'hFFFF_FFFF);

  always_comb begin
    if (div_zero)
      special_res = (div_type == DIV_REM) ? vs2_data : 32'hFFFF_FFFF;
    else
      special_res = (div_type == DIV_REM) ? 32'h0 : 32'h8000_0000;
  end

  assign q_fix = neg_q ? (~quo + 1'b1) : quo;
  assign r_fix = neg_r ? (~rem[31:0] + 1'b1) : rem[31:0];

  assign exception_du = 1'b0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dtype    <= 1'b0;
      wdata_du <= '0;
      busy_du  <= 1'b0;
      done_du  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            dtype <= div_type;
            if (div_zero || sgn_ovf) begin
              wdata_du <= special_res;
              busy_du  <= 1'b0;
              done_du  <= 1'b1;
              state    <= ST_DONE;
            end else begin
              rem     <= '0;
              quo     <= abs_val(vs2_data, is_signed_div);
              dvsr    <= abs_val(vs1_data, is_signed_div);
              neg_q   <= is_signed_div && (vs2_data[31] ^ vs1_data[31]);
              neg_r   <= is_signed_div && vs2_data[31];
              cnt     <= '0;
              busy_du <= 1'b1;
              done_du <= 1'b0;
              state   <= ST_DIVIDE;
            end
          end else begin
            done_du <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        ST_DIVIDE: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31)
            state <= ST_FIXUP;
        end
        ST_FIXUP: begin
          wdata_du <= (dtype == DIV_REM) ? r_fix : q_fix;
          busy_du  <= 1'b0;
          done_du  <= 1'b1;
          state    <= ST_DONE;
        end
        default: begin
          busy_du <= 1'b0;
          done_du <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_divide_unit.sv
// tb_vector_divide_unit
// Self-checking bench: directed table, handshake/reset sequences and
// randomized operations against an arithmetic reference model.
module tb_vector_divide_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] vs1_data;
  logic [31:0] vs2_data;
  logic        start_div;
  logic        div_type;
  logic        is_signed_div;
  logic [31:0] wdata_du;
  logic        busy_du;
  logic        done_du;
  logic        exception_du;

  int errors = 0;
  int checks = 0;

  vector_divide_unit #(.WIDTH(32)) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .vs1_data      (vs1_data),
    .vs2_data      (vs2_data),
    .start_div     (start_div),
    .div_type      (div_type),
    .is_signed_div (is_signed_div),
    .wdata_du      (wdata_du),
    .busy_du       (busy_du),
    .done_du       (done_du),
    .exception_du  (exception_du)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] a;     // dividend
    logic [31:0] b;     // divisor
    bit          dt;
    bit          sg;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: RISC-V division rules in plain arithmetic.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  input bit dt, input bit sg,
                                  output logic [31:0] res, output int lat);
    logic [31:0] q, r;
    if (b == 32'h0) begin
      q = 32'hFFFF_FFFF; r = a; lat = 1;
    end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'h0; lat = 1;
    end else begin
      lat = 34;
      if (sg) begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end else begin
        q = a / b;
        r = a % b;
      end
    end
    res = dt ? r : q;
  endfunction

  // Issues one operation and reports result, latency and busy cycle count.
  // Returns at the negedge of the done cycle (or after the cycle budget).
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit dt,
                       input bit sg, input bit no_wait, input int intrude,
                       output logic [31:0] res, output int lat, output int busy_n);
    if (!no_wait) @(negedge CLK);
    vs2_data = a; vs1_data = b; div_type = dt; is_signed_div = sg; start_div = 1'b1;
    @(negedge CLK);
    start_div = 1'b0;
    lat = 0; busy_n = 0; res = '0;
    for (int k = 1; k <= 45; k++) begin
      if (busy_du) busy_n++;
      if (done_du) begin
        res = wdata_du;
        lat = k;
        break;
      end
      if (k == intrude) begin
        vs2_data = 32'h0000_FFFF; vs1_data = 32'h1;
        div_type = ~dt; is_signed_div = ~sg; start_div = 1'b1;
      end else begin
        start_div = 1'b0;
      end
      @(negedge CLK);
    end
    start_div = 1'b0;
  endtask

  task automatic run_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input bit dt, input bit sg, input logic [31:0] exp,
                           input int exp_lat, input bit no_wait, input int intrude,
                           input bit hold);
    logic [31:0] res;
    int lat, busy_n;
    do_op(a, b, dt, sg, no_wait, intrude, res, lat, busy_n);
    check({tag, " result"}, res, exp);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy cycles"}, busy_n, (exp_lat == 34) ? 33 : 0);
    check({tag, " exception"}, {31'b0, exception_du}, 32'h0);
    if (hold) begin
      @(negedge CLK);
      check({tag, " hold wdata"}, wdata_du, exp);
      check({tag, " done drop"}, {31'b0, done_du}, 32'h0);
    end
  endtask

  initial begin
    logic [31:0] ra, rb, rexp;
    bit rdt, rsg;
    int rlat, dones;

    vecs[0]  = '{32'd100,        32'd7,          1'b0, 1'b0, 32'd14,         34};
    vecs[1]  = '{32'd100,        32'd7,          1'b1, 1'b0, 32'd2,          34};
    vecs[2]  = '{32'hFFFF_FF9C,  32'd7,          1'b0, 1'b1, 32'hFFFF_FFF2,  34};
    vecs[3]  = '{32'hFFFF_FF9C,  32'd7,          1'b1, 1'b1, 32'hFFFF_FFFE,  34};
    vecs[4]  = '{32'hFFFF_FFFF,  32'd2,          1'b0, 1'b0, 32'h7FFF_FFFF,  34};
    vecs[5]  = '{32'h0000_1234,  32'd0,          1'b0, 1'b0, 32'hFFFF_FFFF,  1};
    vecs[6]  = '{32'h0000_1234,  32'd0,          1'b1, 1'b0, 32'h0000_1234,  1};
    vecs[7]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 1'b1, 32'h8000_0000,  1};
    vecs[8]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b1, 32'h0,          1};
    vecs[9]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 1'b0, 32'h0,          34};
    vecs[10] = '{32'hFFFF_FF9C,  32'd0,          1'b1, 1'b1, 32'hFFFF_FF9C,  1};

    nRST = 1'b0; start_div = 1'b0; div_type = 1'b0; is_signed_div = 1'b0;
    vs1_data = '0; vs2_data = '0;
    @(negedge CLK);
    check("reset wdata", wdata_du, 32'h0);
    check("reset busy", {31'b0, busy_du}, 32'h0);
    check("reset done", {31'b0, done_du}, 32'h0);
    check("reset exception", {31'b0, exception_du}, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;

    foreach (vecs[i])
      run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].dt, vecs[i].sg,
                vecs[i].exp, vecs[i].lat, 1'b0, 0, 1'b1);

    // Start with other operands in cycle 10 must be ignored.
    run_check("ignore start", 32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 34, 1'b0, 10, 1'b1);

    // Back-to-back: new starts issued in the DONE cycle.
    run_check("b2b first", 32'hFFFF_FF9C, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 34, 1'b0, 0, 1'b0);
    run_check("b2b second", 32'd1000, 32'd3, 1'b0, 1'b0, 32'd333, 34, 1'b1, 0, 1'b0);
    run_check("b2b special", 32'h0000_5555, 32'd0, 1'b1, 1'b0, 32'h0000_5555, 1, 1'b1, 0, 1'b1);

    // Reset during cycle 15 of DIVIDE.
    @(negedge CLK);
    vs2_data = 32'hFFFF_FFFF; vs1_data = 32'd3; div_type = 1'b0; is_signed_div = 1'b0;
    start_div = 1'b1;
    @(negedge CLK);
    start_div = 1'b0;
    for (int k = 1; k < 15; k++) @(negedge CLK);
    check("pre-reset busy", {31'b0, busy_du}, 32'h1);
    check("pre-reset wdata", wdata_du, 32'h0000_5555);
    #2 nRST = 1'b0;
    #1;
    check("abort wdata", wdata_du, 32'h0);
    check("abort busy", {31'b0, busy_du}, 32'h0);
    check("abort done", {31'b0, done_du}, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (done_du || busy_du) dones++;
    end
    check("no done after abort", dones, 0);
    run_check("after reset", 32'hFFFF_FFFF, 32'd3, 1'b0, 1'b0, 32'h5555_5555, 34, 1'b0, 0, 1'b1);

    // Randomized operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      ra  = $urandom;
      rdt = 1'($urandom_range(0, 1));
      rsg = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: rb = 32'($urandom_range(1, 16));
        2: rb = 32'hFFFF_FFFF;
        3: rb = 32'h0 - 32'($urandom_range(1, 100));
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      ref_div(ra, rb, rdt, rsg, rexp, rlat);
      run_check($sformatf("rand%0d", n), ra, rb, rdt, rsg, rexp, rlat, 1'b0, 0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
